scan_chain_driver: RTL
======================

Name: scan_chain_driver

Overview:
Controller for the far end of the configuration scan chain. It serializes a parallel configuration word into the chain's data_i/en/clear interface, LSB first. It reads the chain back by capturing the chain's data_o, either destructively or with in-place recirculation. It sits between the bitstream/config logic, which issues one command per word, and a scan_chain instance of length CHAIN_LEN.

Parameters:
CHAIN_LEN, 5, number of flops in the attached scan chain (>=2)
CLEAR_CYCLES, 3, cycles sc_clear_o is held low for a CLEAR command (>=1)

Ports:
clk  input  1  system clock, rising edge
clear  input  1  reset; asynchronous, active-low
cmd_valid  input  1  command request
cmd_ready  output  1  high when a command can be accepted (IDLE)
cmd_op  input  2  00 LOAD, 01 READ, 10 READ_RESTORE, 11 CLEAR
cmd_word  input  CHAIN_LEN  word to shift in for LOAD; bit 0 enters the chain first
sc_data_o  output  1  serial data to chain data_i
sc_en_o  output  1  shift enable to chain en
sc_clear_o  output  1  to chain clear, active-low
sc_data_i  input  1  serial data from chain data_o
rd_data  output  CHAIN_LEN  captured readback word
rd_valid  output  1  one-cycle pulse: rd_data updated (READ/READ_RESTORE only)
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse at command completion

Behaviour:
- Reset (clear=0, async): state IDLE, cmd_ready=1, sc_en_o=0, sc_data_o=0, sc_clear_o=1, rd_data=0, rd_valid=0, busy=0, done=0, counter=0, shift register=0. All outputs are registered.
- States: IDLE, SHIFT, CLR, DONE.
- Accept: on a rising edge with cmd_valid && cmd_ready, latch cmd_op.
  - LOAD: also load cmd_word into the internal shift register.
  - READ: shift register is loaded with 0.
  - Non-CLEAR ops go to SHIFT; CLEAR goes to CLR.
  - cmd_valid while busy is ignored, not queued.
- SHIFT: lasts exactly CHAIN_LEN cycles with sc_en_o=1.
  - Each edge in SHIFT: sample sc_data_i into capture register position k (k = 0..CHAIN_LEN-1, in order).
  - sc_data_o for cycle k is: LOAD → cmd_word[k]; READ → 0; READ_RESTORE → the value of sc_data_i sampled on the same edge, combinationally forwarded through a registered mux select.
  - The READ_RESTORE path must leave the chain contents unchanged after CHAIN_LEN shifts.
  - Counter width is clog2(CHAIN_LEN+1). It terminates at CHAIN_LEN-1, then goes to DONE.
- Capture ordering: sample k is the chain's output-end bit before shift k. Therefore a LOAD of word W followed by a READ yields rd_data == W.
- CLR: sc_clear_o=0 and sc_en_o=0 for exactly CLEAR_CYCLES cycles, then DONE. rd_data is not modified.
- DONE: one cycle. sc_en_o=0, sc_data_o=0, done=1. rd_valid=1 and rd_data is updated from the capture register only for READ/READ_RESTORE. Next edge goes to IDLE.
- Latency: accept at edge 0; sc_en_o high in cycles 1..CHAIN_LEN; done in cycle CHAIN_LEN+1; cmd_ready high again from cycle CHAIN_LEN+2. CLEAR: done in cycle CLEAR_CYCLES+1.
- sc_data_o is 0 whenever sc_en_o=0.
- Reset mid-operation: abort immediately; all outputs return to reset values with no done pulse. Chain contents are then undefined to the driver; software must re-LOAD.
- cmd_op is sampled only at accept. Changes while busy have no effect.

Test Plan:
- LOAD 5'b11011 (CHAIN_LEN=5) with behavioural chain model → sc_en_o high exactly 5 cycles; sc_data_o = 1,1,0,1,1; done pulse in cycle 6; chain holds 11011.
- After that LOAD, issue READ → rd_data=5'b11011 with rd_valid pulse; chain model afterwards holds 00000; a second READ returns 5'b00000.
- LOAD 5'b10010, READ_RESTORE, READ → both reads return 5'b10010; the second leaves the chain zeroed.
- LOAD 5'b11111, CLEAR → sc_clear_o low exactly 3 cycles with sc_en_o=0; done once; rd_valid not pulsed; subsequent READ returns 5'b00000.
- Hold cmd_valid high with LOAD then READ back-to-back → READ accepted only when cmd_ready returns, in cycle 7 after the first accept; no overlapping sc_en_o windows.
- Assert clear low during cycle 3 of a LOAD, asynchronously between edges → sc_en_o, busy, sc_data_o drop to 0 immediately; no done; after release, LOAD 5'b01011 + READ returns 5'b01011.

Source files
------------

// File: rtl/scan_chain_driver.sv
// Drives the far end of the configuration scan chain: LOAD, READ, READ_RESTORE, CLEAR.
// Command to done pulse takes CHAIN_LEN+1 cycles (CLEAR_CYCLES+1 for CLEAR); cmd_ready is high only in IDLE.
// A cmd_valid seen while busy is dropped, not queued; the chain never stalls the driver.
module scan_chain_driver #(
  parameter int CHAIN_LEN    = 5,
  parameter int CLEAR_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CHAIN_LEN-1:0] cmd_word,
  output logic                 sc_data_o,
  output logic                 sc_en_o,
  output logic                 sc_clear_o,
  input  logic                 sc_data_i,
  output logic [CHAIN_LEN-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int SHIFT_W = $clog2(CHAIN_LEN + 1);
  localparam int CLR_W   = $clog2(CLEAR_CYCLES + 1);
  // One counter serves both SHIFT and CLR, so it must also fit a long clear.
  localparam int CNT_W   = (SHIFT_W > CLR_W) ? SHIFT_W : CLR_W;

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLEAR_CYCLES - 1);

  localparam logic [1:0] OP_LOAD    = 2'b00;
  localparam logic [1:0] OP_READ    = 2'b01;
  localparam logic [1:0] OP_RESTORE = 2'b10;
  localparam logic [1:0] OP_CLEAR   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CLR   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state;
  logic [1:0]           op_q;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-2:0] shreg;
  logic [CHAIN_LEN-2:0] cap;
  logic [CHAIN_LEN-1:0] cap_nxt;
  logic                 data_q;
  logic                 restore_sel;

  // Bit 0 of the load word goes straight to data_q at accept, so shreg only holds the rest.
  // Likewise the newest sample lives in cap_nxt, and cap keeps only the older ones.
  assign cap_nxt = {sc_data_i, cap};

  // READ_RESTORE feeds the chain output straight back into its input for a pure rotation.
  assign sc_data_o = restore_sel ? sc_data_i : data_q;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state       <= IDLE;
      op_q        <= OP_LOAD;
      cnt         <= '0;
      shreg       <= '0;
      cap         <= '0;
      data_q      <= 1'b0;
      restore_sel <= 1'b0;
      cmd_ready   <= 1'b1;
      sc_en_o     <= 1'b0;
      sc_clear_o  <= 1'b1;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q      <= cmd_op;
            cnt       <= '0;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            if (cmd_op == OP_CLEAR) begin
              state      <= CLR;
              sc_clear_o <= 1'b0;
            end else begin
              state       <= SHIFT;
              sc_en_o     <= 1'b1;
              restore_sel <= (cmd_op == OP_RESTORE);
              data_q      <= (cmd_op == OP_LOAD) ? cmd_word[0] : 1'b0;
              shreg       <= (cmd_op == OP_LOAD) ? cmd_word[CHAIN_LEN-1:1] : '0;
            end
          end
        end

        SHIFT: begin
          cap   <= cap_nxt[CHAIN_LEN-1:1];
          shreg <= shreg >> 1;
          if (cnt == SHIFT_LAST) begin
            state       <= DONE;
            sc_en_o     <= 1'b0;
            data_q      <= 1'b0;
            restore_sel <= 1'b0;
            done        <= 1'b1;
            if (op_q == OP_READ || op_q == OP_RESTORE) begin
              rd_data  <= cap_nxt;
              rd_valid <= 1'b1;
            end
          end else begin
            cnt    <= cnt + CNT_W'(1);
            data_q <= shreg[0];
          end
        end

        CLR: begin
          if (cnt == CLR_LAST) begin
            state      <= DONE;
            sc_clear_o <= 1'b1;
            done       <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DONE: begin
          state     <= IDLE;
          cnt       <= '0;
          done      <= 1'b0;
          rd_valid  <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
